// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// The optional bus watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int SEL_W              = DEF_DATA_W / 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int WDOG_CNT_W         = 16;

  // A transfer is in flight whenever the FSM owns the bus.
  function automatic logic is_busy(input arb_state_t s);
    return (s == DATA) || (s == FETCH);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus wait watchdog for mem_port_arbiter (used only with MEM_ARB_TIMEOUT_EN).
// Counts wait cycles of the current transfer and aborts it once the count
// reaches TIMEOUT_CYCLES (expected to be at least 1 and to fit the counter).
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_i,
  input  logic busy_i,
  input  logic done_i,
  output logic abort_o,
  output logic timeout_o
);

  localparam logic [WDOG_CNT_W-1:0] LAST_WAIT = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_CNT_W-1:0] cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  // The abort fires on the edge that would complete the last allowed wait cycle.
  assign abort_o   = busy_i & ~done_i & (cnt_q == LAST_WAIT);
  assign timeout_o = timeout_q;

  // Next-state for the wait counter and the one-cycle timeout pulse.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = abort_o;
    if (grant_i) begin
      cnt_d = {WDOG_CNT_W{1'b0}};
    end else if (busy_i && !done_i && !abort_o) begin
      cnt_d = cnt_q + {{(WDOG_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= {WDOG_CNT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one Wishbone-style master port between instruction fetch
// (IF) and load/store (MEM). Data has fixed priority because it belongs to
// the older instruction. stall_pipl holds the pipeline until every active
// request of the current step has been served.
// Optional bus watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_sel,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_err,
  output logic                stall_pipl,
  output logic                bus_cyc,
  output logic                bus_stb,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_adr,
  output logic [DATA_W-1:0]   bus_dat_o,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic [DATA_W-1:0]   bus_dat_i,
  input  logic                bus_ack,
  input  logic                bus_err,
  output logic                bus_timeout
);

  localparam int SW = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              if_served_q, if_served_d;
  logic              dm_served_q, dm_served_d;
  logic              bus_cyc_q, bus_cyc_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_adr_q, bus_adr_d;
  logic [DATA_W-1:0] bus_dat_o_q, bus_dat_o_d;
  logic [SW-1:0]     bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_err_q, if_err_d;
  logic              dm_err_q, dm_err_d;

  logic grant_s;
  logic busy_s;
  logic done_s;
  logic abort_s;
  logic fail_s;
  logic advance_s;

  // Stall while any active request of this pipeline step is still unserved.
  assign stall_pipl = (if_req & ~if_served_q) | (dm_req & ~dm_served_q);
  assign advance_s  = ~stall_pipl;
  assign busy_s     = is_busy(state_q);
  assign done_s     = bus_ack | bus_err;
  // An error or a watchdog abort both end the transfer with err=1, rdata=0.
  assign fail_s     = bus_err | abort_s;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .grant_i   (grant_s),
    .busy_i    (busy_s),
    .done_i    (done_s),
    .abort_o   (abort_s),
    .timeout_o (bus_timeout)
  );
`else
  assign abort_s     = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  assign bus_cyc   = bus_cyc_q;
  assign bus_stb   = bus_cyc_q;
  assign bus_we    = bus_we_q;
  assign bus_adr   = bus_adr_q;
  assign bus_dat_o = bus_dat_o_q;
  assign bus_sel   = bus_sel_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;

  // Grant/complete FSM: picks the owner, launches and retires bus transfers.
  always_comb begin
    state_d     = state_q;
    if_served_d = if_served_q;
    dm_served_d = dm_served_q;
    bus_cyc_d   = bus_cyc_q;
    bus_we_d    = bus_we_q;
    bus_adr_d   = bus_adr_q;
    bus_dat_o_d = bus_dat_o_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_err_d    = if_err_q;
    dm_err_d    = dm_err_q;
    grant_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req && !dm_served_q) begin
          state_d     = DATA;
          grant_s     = 1'b1;
          bus_cyc_d   = 1'b1;
          bus_we_d    = dm_we;
          bus_adr_d   = dm_addr;
          bus_dat_o_d = dm_wdata;
          bus_sel_d   = dm_sel;
        end else if (if_req && !if_served_q) begin
          state_d     = FETCH;
          grant_s     = 1'b1;
          bus_cyc_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_adr_d   = if_addr;
          bus_sel_d   = {SW{1'b1}};
        end else begin
          state_d     = IDLE;
        end
      end
      DATA: begin
        if (done_s || abort_s) begin
          state_d     = IDLE;
          bus_cyc_d   = 1'b0;
          dm_served_d = 1'b1;
          dm_rdata_d  = fail_s ? {DATA_W{1'b0}} : bus_dat_i;
          dm_err_d    = fail_s;
        end else begin
          state_d     = DATA;
        end
      end
      FETCH: begin
        if (done_s || abort_s) begin
          state_d     = IDLE;
          bus_cyc_d   = 1'b0;
          if_served_d = 1'b1;
          if_rdata_d  = fail_s ? {DATA_W{1'b0}} : bus_dat_i;
          if_err_d    = fail_s;
        end else begin
          state_d     = FETCH;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_cyc_d = 1'b0;
      end
    endcase

    // Advance edge: the step is over, so forget who was served. A transfer
    // still in flight for a dropped request is thereby discarded.
    if (advance_s) begin
      if_served_d = 1'b0;
      dm_served_d = 1'b0;
    end else begin
      if_served_d = if_served_d;
      dm_served_d = dm_served_d;
    end
  end

  // State, bus and result registers; reset drops the bus cycle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      if_served_q <= 1'b0;
      dm_served_q <= 1'b0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_adr_q   <= {ADDR_W{1'b0}};
      bus_dat_o_q <= {DATA_W{1'b0}};
      bus_sel_q   <= {SW{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_served_q <= if_served_d;
      dm_served_q <= dm_served_d;
      bus_cyc_q   <= bus_cyc_d;
      bus_we_q    <= bus_we_d;
      bus_adr_q   <= bus_adr_d;
      bus_dat_o_q <= bus_dat_o_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_err_q    <= if_err_d;
      dm_err_q    <= dm_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of pipeline steps, a
// reset-during-fetch sequence, randomized steps against a step-level model,
// and (with MEM_ARB_TIMEOUT_EN) a watchdog abort sequence.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_sel;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_err, dm_err, stall_pipl;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel;
  logic        bus_ack, bus_err, bus_timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_sel(dm_sel), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .stall_pipl(stall_pipl),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_sel(bus_sel), .bus_dat_i(bus_dat_i),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_timeout(bus_timeout)
  );

  // One pipeline step: requests, bus slave behaviour, expected results.
  // Error mode: 0 = ack, 1 = err only, 2 = err together with ack.
  typedef struct {
    logic        ifr;  logic [31:0] ia;
    logic        dmr;  logic        we;  logic [31:0] da; logic [31:0] wd; logic [3:0] sel;
    int          wdm;  int          wif; int          edm; int          eif;
    logic [31:0] rdm;  logic [31:0] rif;
    int          x_stall; logic [31:0] x_ird; logic [31:0] x_drd; logic x_ie; logic x_de;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Step-level reference state: the last result each requester received.
  logic [31:0] m_ird, m_drd;
  logic        m_ie, m_de;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic ifr, input logic [31:0] ia, input logic dmr,
                               input logic we, input logic [31:0] da, input logic [31:0] wd,
                               input logic [3:0] sel, input int wdm, input int wif,
                               input int edm, input int eif, input logic [31:0] rdm,
                               input logic [31:0] rif, input int xs, input logic [31:0] xird,
                               input logic [31:0] xdrd, input logic xie, input logic xde);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dmr = dmr; v.we = we; v.da = da; v.wd = wd; v.sel = sel;
    v.wdm = wdm; v.wif = wif; v.edm = edm; v.eif = eif; v.rdm = rdm; v.rif = rif;
    v.x_stall = xs; v.x_ird = xird; v.x_drd = xdrd; v.x_ie = xie; v.x_de = xde;
    return v;
  endfunction

  // Each served request costs one grant cycle plus (waits+1) strobe cycles;
  // failed transfers return zero data and raise err.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   s;
    r = v;
    s = 0;
    if (v.dmr) begin
      s    = s + 2 + v.wdm;
      m_drd = (v.edm != 0) ? 32'h0 : v.rdm;
      m_de  = (v.edm != 0);
    end
    if (v.ifr) begin
      s    = s + 2 + v.wif;
      m_ird = (v.eif != 0) ? 32'h0 : v.rif;
      m_ie  = (v.eif != 0);
    end
    r.x_stall = s;
    r.x_ird = m_ird; r.x_drd = m_drd; r.x_ie = m_ie; r.x_de = m_de;
    return r;
  endfunction

  // Drive a step at a negedge, play the bus slave until stall_pipl falls,
  // then check the results seen in the first non-stalled cycle.
  task automatic run_step(input vec_t v);
    int   st_cnt, nx, wcnt, w, e;
    bit   done, own_dm;
    if_req = v.ifr; if_addr = v.ia;
    dm_req = v.dmr; dm_we = v.we; dm_addr = v.da; dm_wdata = v.wd; dm_sel = v.sel;
    st_cnt = 0; nx = 0; wcnt = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (!stall_pipl) begin
        done = 1'b1;
      end else begin
        st_cnt++;
        chk("stb_eq_cyc", {31'd0, bus_stb}, {31'd0, bus_cyc});
        bus_ack = 1'b0; bus_err = 1'b0; bus_dat_i = $urandom;
        if (bus_cyc) begin
          own_dm = v.dmr && (nx == 0);
          w = own_dm ? v.wdm : v.wif;
          e = own_dm ? v.edm : v.eif;
          if (own_dm) begin
            chk("dm_adr", bus_adr, v.da);
            chk("dm_we", {31'd0, bus_we}, {31'd0, v.we});
            chk("dm_sel", {28'd0, bus_sel}, {28'd0, v.sel});
            if (v.we) chk("dm_dat_o", bus_dat_o, v.wd);
          end else begin
            chk("if_adr", bus_adr, v.ia);
            chk("if_we", {31'd0, bus_we}, 32'd0);
            chk("if_sel", {28'd0, bus_sel}, 32'h0000000F);
          end
          if (wcnt == w) begin
            bus_dat_i = own_dm ? v.rdm : v.rif;
            bus_ack   = (e != 1);
            bus_err   = (e != 0);
            nx++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
        @(negedge clk);
      end
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL step_bound: stall_pipl still high after 400 cycles");
    end
    chk("stall_cycles", st_cnt, v.x_stall);
    chk("if_rdata", if_rdata, v.x_ird);
    chk("dm_rdata", dm_rdata, v.x_drd);
    chk("if_err", {31'd0, if_err}, {31'd0, v.x_ie});
    chk("dm_err", {31'd0, dm_err}, {31'd0, v.x_de});
  endtask

  vec_t tbl[7];
  vec_t v, vr;

  initial begin
    #2000000;
    $display("FAIL global_bound: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0; dm_sel = 4'h0;
    bus_dat_i = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
    m_ird = 32'h0; m_drd = 32'h0; m_ie = 1'b0; m_de = 1'b0;

    // ifr ia       dmr we da        wd           sel    wdm wif edm eif rdm           rif          xs xird      xdrd          xie xde
    tbl[0] = mkv(1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0,  0, 0, 0, 0, 32'h0,        32'h13,       2, 32'h13,   32'h0,        0, 0);
    tbl[1] = mkv(1, 32'h104, 1, 0, 32'h2000, 32'h0,        4'hF,  0, 0, 0, 0, 32'hCAFE0001, 32'h93,       4, 32'h93,   32'hCAFE0001, 0, 0);
    tbl[2] = mkv(0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3,  3, 0, 0, 0, 32'h11111111, 32'h0,        5, 32'h93,   32'h11111111, 0, 0);
    tbl[3] = mkv(0, 32'h0,   1, 0, 32'h3000, 32'h0,        4'hF,  0, 0, 2, 0, 32'h55555555, 32'h0,        2, 32'h93,   32'h0,        0, 1);
    tbl[4] = mkv(1, 32'h108, 0, 0, 32'h0,    32'h0,        4'h0,  0, 2, 0, 1, 32'h0,        32'h66666666, 4, 32'h0,    32'h0,        1, 1);
    tbl[5] = mkv(1, 32'h10C, 1, 0, 32'h3004, 32'h0,        4'hF,  2, 1, 0, 0, 32'hBBBB,     32'hAAAA,     7, 32'hAAAA, 32'hBBBB,     0, 0);
    tbl[6] = mkv(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0,  0, 0, 0, 0, 32'h0,        32'h0,        0, 32'hAAAA, 32'hBBBB,     0, 0);

    // Reset state.
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("rst_stb", {31'd0, bus_stb}, 32'd0);
    chk("rst_adr", bus_adr, 32'h0);
    chk("rst_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    chk("rst_err", {30'd0, if_err, dm_err}, 32'd0);
    chk("rst_stall", {31'd0, stall_pipl}, 32'd0);
    chk("rst_timeout", {31'd0, bus_timeout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed table of pipeline steps.
    for (int i = 0; i < 7; i++) begin
      vr = model(tbl[i]);
      run_step(tbl[i]);
      chk("no_timeout", {31'd0, bus_timeout}, 32'd0);
      @(negedge clk);
    end

    // Reset during a fetch wait: bus drops at once, request is re-issued.
    if_req = 1'b1; if_addr = 32'h400; dm_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (bus_cyc) break;
    end
    chk("pre_rst_cyc", {31'd0, bus_cyc}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("async_rst_stb", {31'd0, bus_stb}, 32'd0);
    chk("rst_stall_req", {31'd0, stall_pipl}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    m_ird = 32'h0; m_drd = 32'h0; m_ie = 1'b0; m_de = 1'b0;
    v = model(mkv(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 32'h0, 32'h77, 0, 32'h0, 32'h0, 0, 0));
    run_step(v);
    @(negedge clk);

    // Randomized steps checked against the step-level model.
    for (int i = 0; i < 40; i++) begin
      v.ifr = 1'($urandom_range(0, 1)); v.ia = $urandom;
      v.dmr = 1'($urandom_range(0, 1)); v.we = 1'($urandom_range(0, 1));
      v.da = $urandom; v.wd = $urandom; v.sel = 4'($urandom_range(0, 15));
      v.wdm = $urandom_range(0, 3); v.wif = $urandom_range(0, 3);
      v.edm = $urandom_range(0, 2); v.eif = $urandom_range(0, 2);
      v.rdm = $urandom; v.rif = $urandom;
      v = model(v);
      if ($urandom_range(0, 3) == 0) begin
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
      end
      run_step(v);
      @(negedge clk);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Fetch with a bus that never answers: watchdog aborts after TO waits.
    v = mkv(1, 32'h500, 0, 0, 32'h0, 32'h0, 4'h0, 0, 100000, 0, 0, 32'h0, 32'h0,
            TO + 1, 32'h0, m_drd, 1, m_de);
    run_step(v);
    chk("timeout_pulse", {31'd0, bus_timeout}, 32'd1);
    @(negedge clk); #1;
    chk("timeout_pulse_end", {31'd0, bus_timeout}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
